// File: rtl/onehot_decoder_seq_pkg.sv
// rtl/onehot_decoder_seq_pkg.sv - shared types and constants for the one-hot decoder
package onehot_decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : onehot_decoder_seq_pkg

// File: rtl/onehot_decoder_seq_if.sv
// rtl/onehot_decoder_seq_if.sv - control/output bundle for the one-hot decoder
interface onehot_decoder_seq_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic [OUT_W-1:0] y;
  logic [SEL_W-1:0] idx;
  logic             y_valid;
  logic             wrap;

  modport master (
    output en, mode, sel, sel_valid,
    input  y, idx, y_valid, wrap
  );

  modport slave (
    input  en, mode, sel, sel_valid,
    output y, idx, y_valid, wrap
  );

endinterface : onehot_decoder_seq_if

// File: rtl/onehot_decoder_seq_onehot_dec.sv
// rtl/onehot_decoder_seq_onehot_dec.sv - combinational binary to one-hot map
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  output logic [2**SEL_W-1:0]   y_o
);

  always_comb begin
    y_o = '0;
    y_o[sel_i] = 1'b1;
  end

endmodule : onehot_dec

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered one-hot decoder with hold and self-timed scan modes
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_decoder_seq_if.slave  bus
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int DIV_W = $clog2(SCAN_DIV + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);
  // XOR mask applied at the output register; all ones inverts to one-cold.
  localparam logic [OUT_W-1:0] Y_MASK   = {OUT_W{ACTIVE_LOW != 0}};

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic               vld_q,   vld_d;
  logic               wrap_q,  wrap_d;
  logic [OUT_W-1:0]   y_q;
  logic [OUT_W-1:0]   onehot_d;
  logic [OUT_W-1:0]   y_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    vld_d   = vld_q;
    wrap_d  = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = '0;
      div_d   = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (bus.mode == MODE_SCAN) begin
            state_d = SCAN;
            idx_d   = '0;
            div_d   = '0;
            vld_d   = 1'b1;
          end else if (bus.sel_valid) begin
            state_d = HOLD;
            idx_d   = bus.sel;
            vld_d   = 1'b1;
          end
        end
        SCAN: begin
          vld_d = 1'b1;
          if (bus.mode == MODE_DECODE) begin
            state_d = HOLD;
            div_d   = '0;
            if (bus.sel_valid) begin
              idx_d = bus.sel;
            end
          end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            idx_d  = idx_q + SEL_W'(1);
            wrap_d = (idx_q == IDX_LAST);
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          div_d   = '0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i (idx_d),
    .y_o   (onehot_d)
  );

  assign y_d = vld_d ? onehot_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      y_q     <= Y_MASK;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d ^ Y_MASK;
    end
  end

  assign bus.y       = y_q;
  assign bus.idx     = idx_q;
  assign bus.y_valid = vld_q;
  assign bus.wrap    = wrap_q;

endmodule : onehot_decoder_seq

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - scoreboard bench for onehot_decoder_seq in two configurations
module tb_onehot_decoder_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq_if #(.SEL_W(3)) b1 ();
  onehot_decoder_seq_if #(.SEL_W(2)) b2 ();

  onehot_decoder_seq #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  onehot_decoder_seq #(.SEL_W(2), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       vld;
    logic       wrap;
  } exp1_t;

  typedef struct packed {
    logic [3:0] y;
    logic       wrap;
  } exp2_t;

  exp1_t q1[$];
  exp2_t q2[$];

  int m_st  = 0;
  int m_idx = 0;
  int m_div = 0;
  bit m_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for the default configuration (SEL_W=3, SCAN_DIV=4, active high).
  task automatic step1();
    exp1_t e;
    bit    wr = 1'b0;
    if (!b1.en) begin
      m_st = 0; m_idx = 0; m_div = 0; m_vld = 1'b0;
    end else if (m_st != 2) begin
      if (b1.mode) begin
        m_st = 2; m_idx = 0; m_div = 0; m_vld = 1'b1;
      end else if (b1.sel_valid) begin
        m_st = 1; m_idx = int'(b1.sel); m_vld = 1'b1;
      end
    end else begin
      if (!b1.mode) begin
        m_st = 1; m_div = 0;
        if (b1.sel_valid) m_idx = int'(b1.sel);
      end else if (m_div == 3) begin
        m_div = 0;
        m_idx = (m_idx + 1) % 8;
        wr    = (m_idx == 0);
      end else begin
        m_div++;
      end
    end
    e.y    = m_vld ? 8'(1 << m_idx) : 8'h00;
    e.idx  = 3'(m_idx);
    e.vld  = m_vld;
    e.wrap = wr;
    q1.push_back(e);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    chk("d1_y",    32'(b1.y),       32'(e.y));
    chk("d1_idx",  32'(b1.idx),     32'(e.idx));
    chk("d1_vld",  32'(b1.y_valid), 32'(e.vld));
    chk("d1_wrap", 32'(b1.wrap),    32'(e.wrap));
  endtask

  task automatic step2(input logic [3:0] ey, input logic ew);
    exp2_t e;
    q2.push_back({ey, ew});
    @(posedge clk);
    #1;
    e = q2.pop_front();
    chk("d2_y",    32'(b2.y),    32'(e.y));
    chk("d2_wrap", 32'(b2.wrap), 32'(e.wrap));
    chk("d2_vld",  32'(b2.y_valid), 32'(1));
  endtask

  initial begin
    int   wraps;
    bit   found;
    logic [3:0] tbl_y [6];
    logic       tbl_w [6];

    b1.en = 1'b0; b1.mode = 1'b0; b1.sel = '0; b1.sel_valid = 1'b0;
    b2.en = 1'b0; b2.mode = 1'b0; b2.sel = '0; b2.sel_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_y1",   32'(b1.y),       32'h00);
    chk("rst_idx1", 32'(b1.idx),     32'h0);
    chk("rst_vld1", 32'(b1.y_valid), 32'h0);
    chk("rst_wrap1",32'(b1.wrap),    32'h0);
    chk("rst_y2",   32'(b2.y),       32'hF);
    rst_n = 1'b1;

    // Decode: single load then hold.
    b1.en = 1'b1; b1.sel = 3'd5; b1.sel_valid = 1'b1;
    step1();
    chk("sel5_y", 32'(b1.y), 32'h20);
    b1.sel_valid = 1'b0;
    repeat (3) step1();
    chk("sel5_hold", 32'(b1.y), 32'h20);

    // Back-to-back loads.
    b1.sel_valid = 1'b1;
    b1.sel = 3'd0; step1(); chk("b2b_0", 32'(b1.y), 32'h01);
    b1.sel = 3'd7; step1(); chk("b2b_7", 32'(b1.y), 32'h80);
    b1.sel = 3'd3; step1(); chk("b2b_3", 32'(b1.y), 32'h08);
    b1.sel_valid = 1'b0;

    // Scan: one full 32-cycle period ends on a single wrap pulse.
    b1.mode = 1'b1;
    wraps = 0;
    for (int i = 0; i < 33; i++) begin
      step1();
      if (i == 0) chk("scan_entry", 32'(b1.y), 32'h01);
      if (b1.wrap) wraps++;
    end
    chk("wrap_count", 32'(wraps), 32'd1);
    chk("wrap_y",     32'(b1.y),  32'h01);
    step1();
    chk("wrap_pulse_len", 32'(b1.wrap), 32'd0);

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (b1.idx == 3'd6) found = 1'b1;
      else step1();
    end
    chk("reach_idx6", 32'(found), 32'd1);
    b1.mode = 1'b0;
    step1();
    chk("freeze_y", 32'(b1.y), 32'h40);
    repeat (2) step1();
    b1.sel = 3'd2; b1.sel_valid = 1'b1;
    step1();
    chk("hold_sel2", 32'(b1.y), 32'h04);

    // HOLD->SCAN ignores a coincident sel_valid; SCAN->HOLD honours one.
    b1.mode = 1'b1; b1.sel = 3'd5;
    step1();
    chk("scan_ignores_sel", 32'(b1.y), 32'h01);
    b1.sel_valid = 1'b0;
    repeat (9) step1();
    b1.mode = 1'b0; b1.sel = 3'd4; b1.sel_valid = 1'b1;
    step1();
    chk("scan_exit_load", 32'(b1.y), 32'h10);
    b1.sel_valid = 1'b0;

    // en drop mid-scan, then restart.
    b1.mode = 1'b1;
    repeat (10) step1();
    b1.en = 1'b0;
    step1();
    chk("en_off_y",   32'(b1.y),       32'h00);
    chk("en_off_vld", 32'(b1.y_valid), 32'h0);
    b1.en = 1'b1;
    step1();
    chk("restart_y",    32'(b1.y),    32'h01);
    chk("restart_wrap", 32'(b1.wrap), 32'h0);
    repeat (5) step1();
    b1.en = 1'b0;
    step1();

    // Active-low, SEL_W=2, SCAN_DIV=1 instance.
    tbl_y = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    tbl_w = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
    b2.en = 1'b1; b2.mode = 1'b1;
    for (int i = 0; i < 6; i++) step2(tbl_y[i], tbl_w[i]);

    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y2",   32'(b2.y),       32'hF);
    chk("async_rst_vld2", 32'(b2.y_valid), 32'h0);
    chk("async_rst_idx2", 32'(b2.idx),     32'h0);
    @(posedge clk);
    #1;
    chk("rst_held_y2", 32'(b2.y), 32'hF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_y2",    32'(b2.y),    32'hE);
    chk("post_rst_wrap2", 32'(b2.wrap), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_onehot_decoder_seq
